// File: rtl/center_of_mass_acc.sv
// Purpose: per-frame centre of mass of thresholded pixels (floor of mean x/y).
// Latency: com_valid_out pulses SUM_W+1 cycles after an accepted tabulate_in.
// Backpressure: none; pixels are always accepted, extra tabulates while busy drop that frame.
module center_of_mass_acc #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int MIN_PIXELS = 16,
    parameter int SUM_W      = 32
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        mask_in,
    input  logic        tabulate_in,
    output logic [10:0] x_com_out,
    output logic [9:0]  y_com_out,
    output logic        com_valid_out,
    output logic        busy_out
);

    // Pixel count width: a full 320x240 frame needs 17 bits.
    localparam int CNT_W  = 17;
    localparam int ITER_W = $clog2(SUM_W);
    localparam logic [ITER_W-1:0] LAST_ITER  = ITER_W'(SUM_W - 1);
    localparam logic [CNT_W-1:0]  MIN_COUNT  = CNT_W'(MIN_PIXELS);
    localparam logic [SUM_W-1:0]  X_MAX_SUM  = SUM_W'(WIDTH - 1);
    localparam logic [SUM_W-1:0]  Y_MAX_SUM  = SUM_W'(HEIGHT - 1);
    localparam logic [10:0]       X_MAX      = 11'(WIDTH - 1);
    localparam logic [9:0]        Y_MAX      = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             r_state;

    // Live accumulators for the frame currently streaming in.
    logic [SUM_W-1:0]   r_x_sum;
    logic [SUM_W-1:0]   r_y_sum;
    logic [CNT_W-1:0]   r_count;

    // Divider: the quotient registers start holding the dividend and shift
    // quotient bits in from the bottom as dividend bits leave the top.
    logic [SUM_W-1:0]   r_div_x_q;
    logic [SUM_W-1:0]   r_div_y_q;
    logic [SUM_W-1:0]   r_div_x_rem;
    logic [SUM_W-1:0]   r_div_y_rem;
    logic [CNT_W-1:0]   r_divisor;
    logic [ITER_W-1:0]  r_iter;

    logic               w_pix;
    logic [SUM_W-1:0]   w_x_ext;
    logic [SUM_W-1:0]   w_y_ext;
    logic [SUM_W:0]     w_divisor_ext;
    logic [SUM_W:0]     w_x_shift;
    logic [SUM_W:0]     w_y_shift;
    logic [SUM_W:0]     w_x_diff;
    logic [SUM_W:0]     w_y_diff;
    logic               w_x_ge;
    logic               w_y_ge;
    logic [10:0]        w_x_quo_clamped;
    logic [9:0]         w_y_quo_clamped;

    assign w_pix         = valid_in & mask_in;
    assign w_x_ext       = SUM_W'(x_in);
    assign w_y_ext       = SUM_W'(y_in);
    assign w_divisor_ext = (SUM_W + 1)'(r_divisor);

    // One restoring-division step for both quotients against the shared divisor.
    // The partial remainder stays below twice the divisor, so the top bit of the
    // difference is a reliable borrow flag.
    always_comb begin
        w_x_shift = {r_div_x_rem, r_div_x_q[SUM_W-1]};
        w_y_shift = {r_div_y_rem, r_div_y_q[SUM_W-1]};
        w_x_diff  = w_x_shift - w_divisor_ext;
        w_y_diff  = w_y_shift - w_divisor_ext;
        w_x_ge    = ~w_x_diff[SUM_W];
        w_y_ge    = ~w_y_diff[SUM_W];
    end

    // Clamp the finished quotients into the visible frame.
    always_comb begin
        w_x_quo_clamped = (r_div_x_q > X_MAX_SUM) ? X_MAX : r_div_x_q[10:0];
        w_y_quo_clamped = (r_div_y_q > Y_MAX_SUM) ? Y_MAX : r_div_y_q[9:0];
    end

    // Live accumulation; a tabulate restarts the frame, and a masked pixel in
    // the tabulate cycle is the first pixel of the new frame.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_x_sum <= '0;
            r_y_sum <= '0;
            r_count <= '0;
        end else if (tabulate_in) begin
            r_x_sum <= w_pix ? w_x_ext : '0;
            r_y_sum <= w_pix ? w_y_ext : '0;
            r_count <= w_pix ? CNT_W'(1) : '0;
        end else if (w_pix) begin
            r_x_sum <= r_x_sum + w_x_ext;
            r_y_sum <= r_y_sum + w_y_ext;
            r_count <= r_count + 1'b1;
        end
    end

    // Control FSM with the divider datapath and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_ACCUM;
            r_div_x_q     <= '0;
            r_div_y_q     <= '0;
            r_div_x_rem   <= '0;
            r_div_y_rem   <= '0;
            r_divisor     <= '0;
            r_iter        <= '0;
            x_com_out     <= '0;
            y_com_out     <= '0;
            com_valid_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            com_valid_out <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    if (tabulate_in) begin
                        // Snapshot the finished frame; too few pixels means no COM.
                        r_div_x_q   <= r_x_sum;
                        r_div_y_q   <= r_y_sum;
                        r_div_x_rem <= '0;
                        r_div_y_rem <= '0;
                        r_divisor   <= r_count;
                        r_iter      <= '0;
                        if (r_count >= MIN_COUNT) begin
                            r_state  <= ST_DIVIDE;
                            busy_out <= 1'b1;
                        end
                    end
                end
                ST_DIVIDE: begin
                    r_div_x_q   <= {r_div_x_q[SUM_W-2:0], w_x_ge};
                    r_div_y_q   <= {r_div_y_q[SUM_W-2:0], w_y_ge};
                    r_div_x_rem <= w_x_ge ? w_x_diff[SUM_W-1:0] : w_x_shift[SUM_W-1:0];
                    r_div_y_rem <= w_y_ge ? w_y_diff[SUM_W-1:0] : w_y_shift[SUM_W-1:0];
                    r_iter      <= r_iter + 1'b1;
                    if (r_iter == LAST_ITER) begin
                        r_state  <= ST_DONE;
                        busy_out <= 1'b0;
                    end
                end
                ST_DONE: begin
                    x_com_out     <= w_x_quo_clamped;
                    y_com_out     <= w_y_quo_clamped;
                    com_valid_out <= 1'b1;
                    r_state       <= ST_ACCUM;
                end
                default: begin
                    r_state  <= ST_ACCUM;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
